// File: rtl/numeros_pkg.sv
// rtl/numeros_pkg.sv - shared widths and state type for the adder/accumulator datapath
package numeros_pkg;

  localparam int DATA_W = 8;
  localparam int ACC_W  = 12;

  typedef enum logic {
    ACUMULA,
    ENTREGA
  } estado_t;

endpackage

// File: rtl/extensor_sinal.sv
// rtl/extensor_sinal.sv - widens a sample to ACC_W, sign- or zero-extended by com_sinal
module extensor_sinal #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 12
) (
  input  logic [DATA_W-1:0] dado,
  input  logic              com_sinal,
  output logic [ACC_W-1:0]  estendido
);

  assign estendido = {{(ACC_W-DATA_W){com_sinal & dado[DATA_W-1]}}, dado};

endmodule

// File: rtl/acumulador_com_sinal.sv
// rtl/acumulador_com_sinal.sv - signed/unsigned block accumulator, saturation via ACUMULADOR_SATURACAO_EN
module acumulador_com_sinal #(
  parameter int DATA_W     = numeros_pkg::DATA_W,
  parameter int ACC_W      = numeros_pkg::ACC_W,
  parameter int N_AMOSTRAS = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] dado_in,
  input  logic              com_sinal,
  input  logic              dado_valido,
  output logic              dado_pronto,
  input  logic              limpar,
  output logic [ACC_W-1:0]  soma,
  output logic              soma_valida,
  input  logic              soma_pronta,
  output logic              estouro
);
  import numeros_pkg::*;

  localparam int CW = $clog2(N_AMOSTRAS);
  localparam logic [CW-1:0] ULTIMA = CW'(N_AMOSTRAS - 1);

  estado_t          estado;
  logic [ACC_W-1:0] acumulador;
  logic [ACC_W-1:0] amostra_ext;
  logic [ACC_W-1:0] proximo;
  logic [ACC_W:0]   soma_bruta;
  logic [CW-1:0]    contagem;
  logic             aceita;
  logic             ovf;

  extensor_sinal #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_extensor (
    .dado      (dado_in),
    .com_sinal (com_sinal),
    .estendido (amostra_ext)
  );

  assign dado_pronto = rst_n && (estado == ACUMULA) && !limpar;
  assign aceita      = dado_valido && dado_pronto;
  assign soma_bruta  = {1'b0, acumulador} + {1'b0, amostra_ext};

  // Overflow rule follows the interpretation of the sample being added.
  always_comb begin
    ovf = com_sinal
        ? ((acumulador[ACC_W-1] == amostra_ext[ACC_W-1]) &&
           (soma_bruta[ACC_W-1] != acumulador[ACC_W-1]))
        : soma_bruta[ACC_W];
    proximo = soma_bruta[ACC_W-1:0];
`ifdef ACUMULADOR_SATURACAO_EN
    if (ovf) begin
      if (!com_sinal)
        proximo = '1;
      else if (acumulador[ACC_W-1])
        proximo = {1'b1, {(ACC_W-1){1'b0}}};
      else
        proximo = {1'b0, {(ACC_W-1){1'b1}}};
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado      <= ACUMULA;
      acumulador  <= '0;
      contagem    <= '0;
      soma        <= '0;
      soma_valida <= 1'b0;
      estouro     <= 1'b0;
    end else if (limpar) begin
      estado      <= ACUMULA;
      acumulador  <= '0;
      contagem    <= '0;
      soma_valida <= 1'b0;
      estouro     <= 1'b0;
    end else begin
      case (estado)
        ACUMULA: begin
          if (aceita) begin
            acumulador <= proximo;
            contagem   <= contagem + 1'b1;
            estouro    <= estouro | ovf;
            if (contagem == ULTIMA) begin
              soma        <= proximo;
              soma_valida <= 1'b1;
              estado      <= ENTREGA;
            end
          end
        end
        ENTREGA: begin
          if (soma_valida && soma_pronta) begin
            soma_valida <= 1'b0;
            acumulador  <= '0;
            contagem    <= '0;
            estouro     <= 1'b0;
            estado      <= ACUMULA;
          end
        end
        default: estado <= ACUMULA;
      endcase
    end
  end

endmodule

// File: doc/acumulador_com_sinal.md
Name: acumulador_com_sinal

Overview:
- Downstream stage of the signed/unsigned adder datapath. It consumes the 8-bit adder result and accumulates N_AMOSTRAS results into a wider sum.
- Each sample is interpreted as signed or unsigned, as indicated by the producer.
- A completed sum is delivered over a valid/ready handshake, with a sticky per-block overflow flag.

Parameters:
- DATA_W, 8, width of incoming samples (adder result width).
- ACC_W, 12, accumulator and output sum width; must be greater than DATA_W.
- N_AMOSTRAS, 4, samples per block; must be 2 or more.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- dado_in  in  DATA_W  sample from the adder stage.
- com_sinal  in  1  1 = dado_in is two's complement; 0 = unsigned. Qualified by the accept.
- dado_valido  in  1  upstream valid.
- dado_pronto  out  1  ready to upstream.
- limpar  in  1  synchronous block clear.
- soma  out  ACC_W  completed block sum.
- soma_valida  out  1  soma is valid.
- soma_pronta  in  1  downstream ready.
- estouro  out  1  sticky overflow flag for the current block.

Behaviour:
- Reset (rst_n low, asynchronous): acumulador=0, contagem=0, soma=0, soma_valida=0, estouro=0, state ACUMULA.
- Ready: dado_pronto = rst_n && state==ACUMULA && !limpar. This is combinational.
- States:
  - ACUMULA: accept occurs when dado_valido && dado_pronto.
    - On accept: acumulador <= acumulador + ext(dado_in); contagem <= contagem+1.
    - ext() sign-extends dado_in to ACC_W when com_sinal=1, and zero-extends it when com_sinal=0.
    - On the accept where contagem==N_AMOSTRAS-1: soma <= the updated sum; soma_valida <= 1; go to ENTREGA.
    - soma_valida therefore rises exactly 1 cycle after the N-th accept.
  - ENTREGA: soma, estouro and soma_valida are held stable; dado_pronto=0.
    - When soma_valida && soma_pronta: soma_valida <= 0; acumulador <= 0; contagem <= 0; estouro <= 0; go to ACUMULA.
    - The first sample of the next block can be accepted the cycle after the handshake.
- Overflow detection, evaluated per accept using that sample's com_sinal:
  - Signed (com_sinal=1): both operands have the same sign and the result sign differs.
  - Unsigned (com_sinal=0): carry out of bit ACC_W-1.
  - estouro is set on any overflowing accept and stays set until the block is delivered, limpar, or reset.
- Without saturation, the sum wraps modulo 2^ACC_W.
- limpar: takes priority over every other event in any state. Next cycle: acumulador=0, contagem=0, soma_valida=0, estouro=0, state ACUMULA. A sample presented in the same cycle is not accepted.
- Reset asserted mid-block or mid-delivery: all state is discarded immediately; no partial sum is ever delivered.
- dado_valido while in ENTREGA: the sample is not consumed; upstream must hold it.

Optional Feature:
- Macro: ACUMULADOR_SATURACAO_EN.
- When defined: an overflowing accept clamps the accumulator instead of wrapping; estouro is still set.
  - Signed sample that overflows positive: clamp to 2^(ACC_W-1)-1.
  - Signed sample that overflows negative: clamp to -2^(ACC_W-1).
  - Unsigned sample: clamp to 2^ACC_W-1.
- When undefined: wrap-around arithmetic only, with no clamp logic present.

Decomposition:
- Shared package numeros_pkg:
  - state enum {ACUMULA, ENTREGA}.
  - Default width constants DATA_W=8 and ACC_W=12.
- Sub-module extensor_sinal (DATA_W to ACC_W, selected by com_sinal). It is also reusable by the adder stage.

Test Plan:
1. Signed block, com_sinal=1, samples 0xFD, 0xFB, 0x0A, 0x01 (-3, -5, +10, +1) -> soma=0x003, estouro=0, soma_valida high 1 cycle after the 4th accept.
2. Unsigned block, com_sinal=0, 0xFF x4 -> soma=0x3FC, estouro=0.
3. Mixed block: 0xFF with com_sinal=1, then 0xFF with com_sinal=0, then 0x00, 0x00 -> soma=0x0FE.
4. Backpressure: soma_pronta held low 5 cycles.
   - During the stall: soma stable, dado_pronto=0, a pending dado_valido is not consumed.
   - After release: the next block starts from 0, and a following 0x01 x4 -> soma=0x004.
5. Overflow with ACC_W=9, com_sinal=1, 0x7F x4 (127 each):
   - Without the macro: soma=0x1FC, estouro=1.
   - With ACUMULADOR_SATURACAO_EN: soma=0x0FF, estouro=1.
6. Abort paths: limpar after 2 accepts -> no delivery, a fresh 4-sample block sums correctly. Then rst_n pulsed low while in ENTREGA -> soma_valida and soma drop to 0 asynchronously, state returns to ACUMULA.
